core_muldiv: RTL and testbench

Parametrised multi-cycle RV32M/RV64M multiply/divide unit for the in-order core's EX stage. It covers all eight M-extension operations with an iterative radix-2^BITS_PER_CYCLE datapath. The unit uses a start/busy/done handshake: the pipeline holds EX-MEM (ex_stall) while o_busy is high and captures o_res on o_done. It supports flush on branch/jalr redirect and a single-cycle fast path for RISC-V divide special cases.

---
 rtl/core_muldiv_pkg.sv | 38 +++
 rtl/core_muldiv_step.sv | 39 +++
 rtl/core_muldiv.sv | 137 +++++++++++++
 tb/tb_core_muldiv.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M/RV64M multiply/divide unit.
// Op encodings follow funct3 of the OP/OP-32 M-extension instructions.
package core_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic is_div_op(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic num1_signed(input logic [2:0] f);
    return (f == OP_MULH) || (f == OP_MULHSU) ||
           (f == OP_DIV)  || (f == OP_REM);
  endfunction

  function automatic logic num2_signed(input logic [2:0] f);
    return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] f);
    return num1_signed(f) || num2_signed(f);
  endfunction

endpackage

// File: rtl/core_muldiv_step.sv
// One CALC iteration: BITS_PER_CYCLE unrolled shift-add (multiply, LSB first)
// or restoring-subtract (divide, MSB first) steps on the shared accumulator.
module core_muldiv_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [2*XLEN-1:0] a;
  logic [XLEN:0]     rsh;
  logic [XLEN:0]     sum;

  // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {hi, multiplier/lo}
  always_comb begin
    a   = acc_in;
    rsh = '0;
    sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        rsh = {a[2*XLEN-1:XLEN], a[XLEN-1]};
        if (rsh >= {1'b0, opnd}) begin
          sum = rsh - {1'b0, opnd};
          a   = {sum[XLEN-1:0], a[XLEN-2:0], 1'b1};
        end else begin
          a   = {rsh[XLEN-1:0], a[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, opnd} : '0);
        a   = {sum, a[XLEN-1:1]};
      end
    end
    acc_out = a;
  end

endmodule

// File: rtl/core_muldiv.sv
// Multi-cycle M-extension unit for EX: start/busy/done handshake,
// flush abort and single-cycle divide special-case path.
module core_muldiv
  import core_muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_num1u,
  input  logic [XLEN-1:0] i_num2u,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic              sgn1, sgn2;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   res;

  logic              s1_in, s2_in;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   spec_res;

  logic              neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_res;

  assign s1_in = num1_signed(i_funct3) & i_num1u[XLEN-1];
  assign s2_in = num2_signed(i_funct3) & i_num2u[XLEN-1];
  assign abs1  = s1_in ? -i_num1u : i_num1u;
  assign abs2  = s2_in ? -i_num2u : i_num2u;

  assign div_zero = ~|i_num2u;
  assign ovf      = ((i_funct3 == OP_DIV) || (i_funct3 == OP_REM)) &&
                    (i_num1u == MIN_NEG) && (&i_num2u);
  assign special  = is_div_op(i_funct3) & (div_zero | ovf);

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div_zero & ~i_funct3[1]: spec_res = '1;
      div_zero &  i_funct3[1]: spec_res = i_num1u;
      ovf & ~i_funct3[1]:      spec_res = MIN_NEG;
      default:                 spec_res = '0;
    endcase
  end

  core_muldiv_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .is_div (is_div_op(f3)),
    .acc_in (acc),
    .opnd   (opnd),
    .acc_out(acc_nxt)
  );

  // Remainder follows the dividend sign; quotient/product follow sign xor
  assign neg  = sgn1 ^ sgn2;
  assign prod = neg ? -acc : acc;
  assign quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = sgn1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      ~f3[2] & (f3[1:0] == 2'b00): fix_res = prod[XLEN-1:0];
      ~f3[2] & (f3[1:0] != 2'b00): fix_res = prod[2*XLEN-1:XLEN];
      f3[2] & ~f3[1]:              fix_res = quo;
      default:                     fix_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      f3    <= '0;
      sgn1  <= 1'b0;
      sgn2  <= 1'b0;
      acc   <= '0;
      opnd  <= '0;
      res   <= '0;
    end else if (i_flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            f3   <= i_funct3;
            sgn1 <= s1_in;
            sgn2 <= s2_in;
            cnt  <= '0;
            acc  <= {{XLEN{1'b0}}, is_div_op(i_funct3) ? abs1 : abs2};
            opnd <= is_div_op(i_funct3) ? abs2 : abs1;
            if (special) begin
              state <= S_DONE;
              res   <= spec_res;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_DONE;
          res   <= fix_res;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);
  assign o_res  = res;

endmodule

// File: tb/tb_core_muldiv.sv
// Bench for core_muldiv: directed checks on a BPC=1 instance and
// randomized ops on a BPC=4 instance against an arithmetic model.
module tb_core_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        start1 = 1'b0, flush1 = 1'b0;
  logic [2:0]  f1 = '0;
  logic [31:0] a1 = '0, b1 = '0;
  logic        busy1, done1;
  logic [31:0] res1;

  logic        start4 = 1'b0, flush4 = 1'b0;
  logic [2:0]  f4 = '0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [31:0] res4;

  typedef struct {
    logic [31:0] res;
    int          t;
    int          due;
  } exp_t;
  exp_t q[$];

  localparam logic [31:0] MINV = 32'h8000_0000;

  core_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_flush(flush1),
    .i_funct3(f1), .i_num1u(a1), .i_num2u(b1),
    .o_busy(busy1), .o_done(done1), .o_res(res1)
  );

  core_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(start4), .i_flush(flush4),
    .i_funct3(f4), .i_num1u(a4), .i_num2u(b4),
    .o_busy(busy4), .o_done(done4), .o_res(res4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f,
                                      input logic [31:0] a, b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'b100 || f == 3'b110) && a == MINV && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a, b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    up = {32'b0, a} * {32'b0, b};
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: return up[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process for the randomized instance
  always @(negedge clk) begin
    logic eb;
    exp_t e;
    if (rst_n) begin
      eb = 1'b0;
      if (q.size() > 0) eb = (cyc > q[0].t);
      chk("busy4", {63'b0, busy4}, {63'b0, eb});
      if (done4) begin
        if (q.size() == 0) begin
          chk("spurious_done4", {63'b0, done4}, 64'h0);
        end else begin
          e = q.pop_front();
          chk("res4", {32'b0, res4}, {32'b0, e.res});
          chk("lat4", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic op1(input string nm, input logic [2:0] f,
                     input logic [31:0] a, b, exp, input int lat);
    int t0, got, bad_busy;
    bit seen;
    f1 = f; a1 = a; b1 = b; start1 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start1 = 1'b0;
    seen = 0; got = 0; bad_busy = 0;
    for (int i = 0; i < lat + 5 && !seen; i++) begin
      @(negedge clk);
      if (busy1 !== 1'b1) bad_busy++;
      if (done1) begin
        seen = 1;
        got = cyc - t0;
        chk({nm, "_res"}, {32'b0, res1}, {32'b0, exp});
      end
    end
    chk({nm, "_lat"}, 64'(got), 64'(lat));
    chk({nm, "_busy"}, 64'(bad_busy), 64'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy1}, 64'h0);
    chk("rst_done", {63'b0, done1}, 64'h0);
    chk("rst_res", {32'b0, res1}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_mul", {32'b0, ref_res(3'b000, 32'd7, 32'hFFFF_FFFD)}, 64'hFFFF_FFEB);
    chk("model_mulhsu", {32'b0, ref_res(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFF);
    chk("model_div", {32'b0, ref_res(3'b100, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFD);
    chk("model_rem", {32'b0, ref_res(3'b110, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFF);

    op1("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    op1("mulh", 3'b001, MINV, MINV, 32'h4000_0000, 34);
    op1("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    op1("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    op1("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    op1("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    op1("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    op1("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    op1("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    op1("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    op1("divovf", 3'b100, MINV, 32'hFFFF_FFFF, MINV, 1);
    op1("removf", 3'b110, MINV, 32'hFFFF_FFFF, 32'd0, 1);
    op1("divu2", 3'b101, 32'd100, 32'd7, 32'd14, 34);

    // Flush at T+10 of a DIV
    f1 = 3'b100; a1 = 32'd1000; b1 = 32'd3; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush1 = 1'b1;
    @(posedge clk); #1 flush1 = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'b0, busy1}, 64'h0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    chk("flush_no_done", 64'(nd), 64'h0);
    chk("flush_res", {32'b0, res1}, 64'd14);
    @(posedge clk); #1;

    // Flush and start together: nothing launched
    f1 = 3'b000; a1 = 32'd9; b1 = 32'd9; start1 = 1'b1; flush1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; flush1 = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {63'b0, busy1}, 64'h0);
    @(posedge clk); #1;

    op1("mul3x4", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // Reset mid-CALC
    f1 = 3'b100; a1 = 32'd77; b1 = 32'd5; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy1}, 64'h0);
    chk("arst_done", {63'b0, done1}, 64'h0);
    chk("arst_res", {32'b0, res1}, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    chk("arst_no_done", 64'(nd), 64'h0);
    @(posedge clk); #1;
    op1("mul3x4b", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // Randomized back-to-back ops with i_start held high
    f4 = 3'($urandom_range(0, 7)); a4 = pick(); b4 = pick();
    start4 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      int   lat;
      exp_t e;
      lat   = is_special(f4, a4, b4) ? 1 : 10;
      e.res = ref_res(f4, a4, b4);
      e.t   = cyc;
      e.due = cyc + lat;
      q.push_back(e);
      @(posedge clk); #1;
      f4 = 3'($urandom_range(0, 7)); a4 = pick(); b4 = pick();
      repeat (lat) @(posedge clk);
      #1;
    end
    start4 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
